// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped, write-through data cache:
// default geometry, the address-field widths derived from it, and the
// controller state encoding.
// ---------------------------------------------------------------------------
package dcache_pkg;

    // Default geometry: 16 lines of 4 x 32-bit words.
    localparam int LINES_DEF = 16;
    localparam int WORDS_DEF = 4;

    // Address split at the default geometry: tag | index | offset | byte.
    localparam int OFFSET_W  = $clog2(WORDS_DEF);
    localparam int INDEX_W   = $clog2(LINES_DEF);
    localparam int TAG_W     = 32 - INDEX_W - OFFSET_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage : dcache_pkg

// File: rtl/dcache_data_array.sv
// ---------------------------------------------------------------------------
// dcache_data_array
// LINES x WORDS x 32-bit data storage.
//   i_clk             : clock
//   i_we[3:0]         : byte write enables (synchronous write port)
//   i_windex/i_woffset: line / word selected for the write
//   i_wdata           : write data, lane-aligned
//   i_rindex/i_roffset: line / word selected for the read
//   o_rdata           : asynchronous read data
// ---------------------------------------------------------------------------
module dcache_data_array #(
    parameter  int LINES = 16,
    parameter  int WORDS = 4,
    localparam int IDX_W = $clog2(LINES),
    localparam int OFF_W = $clog2(WORDS)
) (
    input  logic             i_clk,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_windex,
    input  logic [OFF_W-1:0] i_woffset,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_rindex,
    input  logic [OFF_W-1:0] i_roffset,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [LINES*WORDS];

    // NOTE: storage arrays carry no reset; contents are only trusted once the
    // matching valid bit is set, so a reset network here would buy nothing.
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of its inputs.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[{i_windex, i_woffset}][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[{i_rindex, i_roffset}];

endmodule : dcache_data_array

// File: rtl/dcache.sv
// ---------------------------------------------------------------------------
// dcache
// Direct-mapped, write-through, no-write-allocate data cache.
//   clk, reset        : clock, asynchronous active-high reset
//   dm_req/addr/wen/wdata : CPU request (wen==0 is a read), held until dm_ready
//   dm_rdata, dm_ready    : response word and one-cycle completion pulse
//   mem_rd_*          : line refill (single request, WORDS beats in order)
//   mem_wr_*          : write-through (request held until mem_wr_ack)
// Tag and valid arrays live here; data words live in dcache_data_array.
// ---------------------------------------------------------------------------
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic [3:0]  mem_wr_wen,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_ack
);

    localparam int L_OFF_W = $clog2(WORDS);
    localparam int L_IDX_W = $clog2(LINES);
    localparam int L_TAG_W = 32 - L_IDX_W - L_OFF_W - 2;

    // Registered request and controller state.
    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_addr;
    logic [3:0]           r_wen;
    logic [31:0]          r_wdata;
    logic [L_OFF_W-1:0]   r_beat;
    logic [31:0]          r_rdata;

    // Tag / valid arrays.
    logic [LINES-1:0]     r_valid;
    logic [L_TAG_W-1:0]   r_tag [LINES];

    // Address fields of the registered request.
    logic [L_IDX_W-1:0]   w_index;
    logic [L_OFF_W-1:0]   w_offset;
    logic [L_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic                 w_is_write;
    logic                 w_last_beat;

    // Data-array interface.
    logic [3:0]           w_arr_we;
    logic [L_OFF_W-1:0]   w_arr_off;
    logic [31:0]          w_arr_wdata;
    logic [31:0]          w_arr_rdata;

    // Response path.
    logic                 w_ready;
    logic [31:0]          w_resp_data;

    assign w_index     = r_addr[L_OFF_W+2 +: L_IDX_W];
    assign w_offset    = r_addr[2 +: L_OFF_W];
    assign w_tag       = r_addr[31 -: L_TAG_W];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_is_write  = |r_wen;
    assign w_last_beat = mem_rd_valid && (r_beat == L_OFF_W'(WORDS - 1));

    // Next state, response and array write controls.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_resp_data = '0;
        w_arr_we    = 4'b0000;
        w_arr_off   = w_offset;
        w_arr_wdata = r_wdata;

        case (r_state)
            ST_IDLE: begin
                if (dm_req) begin
                    w_next = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (w_is_write) begin
                    // Write hits update the cached word now; misses leave the
                    // cache alone. Both go through to memory.
                    if (w_hit) begin
                        w_arr_we = r_wen;
                    end
                    w_next = ST_WRITE;
                end else if (w_hit) begin
                    w_ready     = 1'b1;
                    w_resp_data = w_arr_rdata;
                    w_next      = ST_IDLE;
                end else begin
                    w_next = ST_REFILL;
                end
            end

            ST_REFILL: begin
                if (mem_rd_valid) begin
                    w_arr_we    = 4'b1111;
                    w_arr_off   = r_beat;
                    w_arr_wdata = mem_rd_data;
                    if (w_last_beat) begin
                        w_next = ST_RESP;
                    end
                end
            end

            ST_WRITE: begin
                if (mem_wr_ack) begin
                    w_next = ST_RESP;
                end
            end

            ST_RESP: begin
                w_ready     = 1'b1;
                w_resp_data = w_is_write ? 32'h0 : w_arr_rdata;
                w_next      = ST_IDLE;
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_next;
            r_rdata <= dm_rdata;

            if (r_state == ST_IDLE && dm_req) begin
                r_addr  <= dm_addr;
                r_wen   <= dm_wen;
                r_wdata <= dm_wdata;
            end

            // The line is overwritten beat by beat, so it must read as invalid
            // until the final beat lands; an abandoned refill stays invalid.
            if (r_state == ST_LOOKUP && !w_is_write && !w_hit) begin
                r_valid[w_index] <= 1'b0;
            end

            if (r_state == ST_REFILL && mem_rd_valid) begin
                if (w_last_beat) begin
                    r_beat           <= '0;
                    r_valid[w_index] <= 1'b1;
                end else begin
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_REFILL && w_last_beat) begin
            r_tag[w_index] <= w_tag;
        end
    end

    dcache_data_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_data (
        .i_clk     (clk),
        .i_we      (w_arr_we),
        .i_windex  (w_index),
        .i_woffset (w_arr_off),
        .i_wdata   (w_arr_wdata),
        .i_rindex  (w_index),
        .i_roffset (w_offset),
        .o_rdata   (w_arr_rdata)
    );

    // dm_rdata follows the response word during a pulse and holds otherwise.
    assign dm_ready    = w_ready;
    assign dm_rdata    = w_ready ? w_resp_data : r_rdata;

    assign mem_rd_req  = (r_state == ST_REFILL) && (r_beat == '0);
    assign mem_rd_addr = {r_addr[31:L_OFF_W+2], {(L_OFF_W+2){1'b0}}};

    assign mem_wr_req  = (r_state == ST_WRITE);
    assign mem_wr_addr = r_addr;
    assign mem_wr_wen  = r_wen;
    assign mem_wr_data = r_wdata;

endmodule : dcache

// File: tb/tb_dcache.sv
// ---------------------------------------------------------------------------
// tb_dcache
// Directed bench for dcache: the bench plays CPU and backing memory, and
// each comparison is an immediate assertion against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_dcache;

    localparam int WORDS = 4;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          ready_cnt;
        int          rd_req_cyc;
        logic [31:0] rd_addr;
        int          beats;
        int          wr_cyc;
        logic [31:0] wr_addr;
        logic [3:0]  wr_wen;
        logic [31:0] wr_data;
    } acc_t;

    logic        clk;
    logic        reset;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        mem_wr_req;
    logic [31:0] mem_wr_addr;
    logic [3:0]  mem_wr_wen;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ack;

    logic [31:0] mem [4096];
    int          n_checks;
    int          n_fail;

    dcache dut (
        .clk          (clk),
        .reset        (reset),
        .dm_req       (dm_req),
        .dm_addr      (dm_addr),
        .dm_wen       (dm_wen),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ready     (dm_ready),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_req   (mem_wr_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_wen   (mem_wr_wen),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ack   (mem_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One CPU access; the bench also acts as backing memory. Observation and
    // driving happen on the falling edge, away from the DUT's active edge.
    task automatic access(input logic [31:0] addr, input logic [3:0] wen,
                          input logic [31:0] wdata, input int ack_delay,
                          output acc_t r);
        bit          serving;
        bit          done;
        int          k;
        int          post;
        logic [31:0] base;
        r = '{rdata: '0, lat: -1, ready_cnt: 0, rd_req_cyc: 0, rd_addr: '0,
              beats: 0, wr_cyc: 0, wr_addr: '0, wr_wen: '0, wr_data: '0};
        serving = 1'b0;
        done    = 1'b0;
        k       = 0;
        post    = 0;
        base    = '0;
        dm_addr  = addr;
        dm_wen   = wen;
        dm_wdata = wdata;
        dm_req   = 1'b1;
        for (int cyc = 1; cyc <= 60 && post < 3; cyc++) begin
            @(negedge clk);
            if (dm_ready) begin
                r.ready_cnt++;
                if (!done) begin
                    done    = 1'b1;
                    r.rdata = dm_rdata;
                    r.lat   = cyc;
                    dm_req  = 1'b0;
                end
            end
            if (mem_rd_req) begin
                r.rd_req_cyc++;
                r.rd_addr = mem_rd_addr;
                if (!serving) begin
                    serving = 1'b1;
                    base    = mem_rd_addr;
                end
            end
            if (serving && k < WORDS) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[int'(base[13:2]) + k];
                k++;
            end else begin
                mem_rd_valid = 1'b0;
            end
            if (mem_wr_req) begin
                r.wr_cyc++;
                r.wr_addr = mem_wr_addr;
                r.wr_wen  = mem_wr_wen;
                r.wr_data = mem_wr_data;
                if (r.wr_cyc == ack_delay) begin
                    mem_wr_ack = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wr_wen[b]) mem[mem_wr_addr[13:2]][8*b +: 8] = mem_wr_data[8*b +: 8];
                    end
                end else begin
                    mem_wr_ack = 1'b0;
                end
            end else begin
                mem_wr_ack = 1'b0;
            end
            if (done) post++;
        end
        r.beats      = k;
        dm_req       = 1'b0;
        mem_rd_valid = 1'b0;
        mem_wr_ack   = 1'b0;
    endtask

    initial begin
        acc_t r;
        int   seen_ready;
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        dm_req       = 1'b0;
        dm_addr      = '0;
        dm_wen       = '0;
        dm_wdata     = '0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        mem_wr_ack   = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h040] = 32'h11; mem[12'h041] = 32'h22; mem[12'h042] = 32'h33; mem[12'h043] = 32'h44;
        mem[12'h440] = 32'h55; mem[12'h441] = 32'h66; mem[12'h442] = 32'h77; mem[12'h443] = 32'h88;
        mem[12'h0C0] = 32'h91; mem[12'h0C1] = 32'h92; mem[12'h0C2] = 32'h93; mem[12'h0C3] = 32'h94;

        // Reset values.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_dm_ready",    {31'b0, dm_ready},   32'h0);
        check("rst_dm_rdata",    dm_rdata,            32'h0);
        check("rst_mem_rd_req",  {31'b0, mem_rd_req}, 32'h0);
        check("rst_mem_rd_addr", mem_rd_addr,         32'h0);
        check("rst_mem_wr_req",  {31'b0, mem_wr_req}, 32'h0);
        check("rst_mem_wr_addr", mem_wr_addr,         32'h0);
        check("rst_mem_wr_wen",  {28'b0, mem_wr_wen}, 32'h0);
        check("rst_mem_wr_data", mem_wr_data,         32'h0);

        // Cold read of 0x108: line refill from 0x100.
        access(32'h108, 4'b0000, 32'h0, 1, r);
        check("cold_rd_addr",   r.rd_addr,    32'h100);
        check("cold_rd_req",    r.rd_req_cyc, 1);
        check("cold_beats",     r.beats,      4);
        check("cold_ready_cnt", r.ready_cnt,  1);
        check("cold_rdata",     r.rdata,      32'h33);
        check("cold_wr_cyc",    r.wr_cyc,     0);

        // Read hit of 0x10C.
        access(32'h10C, 4'b0000, 32'h0, 1, r);
        check("hit_lat",    r.lat,        1);
        check("hit_rdata",  r.rdata,      32'h44);
        check("hit_rd_req", r.rd_req_cyc, 0);
        check("hit_ready",  r.ready_cnt,  1);

        // Write hit of 0x104, byte lane 1, immediate ack.
        access(32'h104, 4'b0010, 32'h0000AB00, 1, r);
        check("wh_wr_addr", r.wr_addr,           32'h104);
        check("wh_wr_wen",  {28'b0, r.wr_wen},   32'h2);
        check("wh_wr_data", r.wr_data,           32'h0000AB00);
        check("wh_wr_cyc",  r.wr_cyc,            1);
        check("wh_ready",   r.ready_cnt,         1);
        check("wh_rdata",   r.rdata,             32'h0);
        check("wh_rd_req",  r.rd_req_cyc,        0);
        access(32'h104, 4'b0000, 32'h0, 1, r);
        check("wh_rb_lat",    r.lat,        1);
        check("wh_rb_rdata",  r.rdata,      32'h0000AB22);
        check("wh_rb_rd_req", r.rd_req_cyc, 0);
        check("rdata_hold",   dm_rdata,     32'h0000AB22);

        // Write miss of 0x200 with ack in the third request cycle.
        access(32'h200, 4'b1111, 32'hDEADBEEF, 3, r);
        check("wm_wr_cyc", r.wr_cyc,    3);
        check("wm_ready",  r.ready_cnt, 1);
        check("wm_rdata",  r.rdata,     32'h0);
        access(32'h200, 4'b0000, 32'h0, 1, r);
        check("wm_rb_rd_req", r.rd_req_cyc, 1);
        check("wm_rb_addr",   r.rd_addr,    32'h200);
        check("wm_rb_rdata",  r.rdata,      32'hDEADBEEF);

        // Conflict eviction on index 0.
        access(32'h100, 4'b0000, 32'h0, 1, r);
        check("cf_a_rd_req", r.rd_req_cyc, 1);
        check("cf_a_rdata",  r.rdata,      32'h11);
        access(32'h1100, 4'b0000, 32'h0, 1, r);
        check("cf_b_rd_req", r.rd_req_cyc, 1);
        check("cf_b_addr",   r.rd_addr,    32'h1100);
        check("cf_b_rdata",  r.rdata,      32'h55);
        access(32'h100, 4'b0000, 32'h0, 1, r);
        check("cf_c_rd_req", r.rd_req_cyc, 1);
        check("cf_c_rdata",  r.rdata,      32'h11);

        // Reset after the second refill beat of 0x308.
        seen_ready = 0;
        dm_addr  = 32'h308;
        dm_wen   = 4'b0000;
        dm_wdata = '0;
        dm_req   = 1'b1;
        @(negedge clk);                       // LOOKUP (miss)
        seen_ready += dm_ready;
        @(negedge clk);                       // REFILL, request out
        seen_ready += dm_ready;
        check("ab_rd_req_on", {31'b0, mem_rd_req}, 32'h1);
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem[12'h0C0];
        @(negedge clk);
        seen_ready += dm_ready;
        mem_rd_data  = mem[12'h0C1];
        @(negedge clk);                       // two beats taken
        seen_ready += dm_ready;
        reset        = 1'b1;
        mem_rd_valid = 1'b0;
        dm_req       = 1'b0;
        #1;
        seen_ready += dm_ready;
        check("ab_rd_req_rst", {31'b0, mem_rd_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen_ready += dm_ready;
        end
        check("ab_no_ready",   seen_ready,          0);
        check("ab_rd_req_off", {31'b0, mem_rd_req}, 32'h0);
        access(32'h308, 4'b0000, 32'h0, 1, r);
        check("ab_rb_rd_req", r.rd_req_cyc, 1);
        check("ab_rb_addr",   r.rd_addr,    32'h300);
        check("ab_rb_beats",  r.beats,      4);
        check("ab_rb_rdata",  r.rdata,      32'h93);
        access(32'h30C, 4'b0000, 32'h0, 1, r);
        check("ab_hit_lat",   r.lat,        1);
        check("ab_hit_rdata", r.rdata,      32'h94);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dcache

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped lines.
REQ-002 The block SHALL have parameter WORDS, default 4, meaning the number of 32-bit words per line.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port dm_req, input, 1 bit: a CPU access is pending.
REQ-006 The block SHALL have port dm_addr, input, 32 bits: the byte address (bits [1:0] ignored for the lookup).
REQ-007 The block SHALL have port dm_wen, input, 4 bits: byte write enables; 4'b0000 means a read.
REQ-008 The block SHALL have port dm_wdata, input, 32 bits: store data, already lane-aligned.
REQ-009 The block SHALL have port dm_rdata, output, 32 bits: the full read word.
REQ-010 The block SHALL have port dm_ready, output, 1 bit: a one-cycle pulse meaning the access is complete.
REQ-011 The block SHALL have ports mem_rd_req (out, 1), mem_rd_addr (out, 32, line-aligned), mem_rd_valid (in, 1) and mem_rd_data (in, 32) for refill.
REQ-012 The block SHALL have ports mem_wr_req (out, 1), mem_wr_addr (out, 32), mem_wr_wen (out, 4), mem_wr_data (out, 32) and mem_wr_ack (in, 1) for write-through.

Function
REQ-013 The cache SHALL be direct-mapped, write-through and no-write-allocate, with address fields offset=[3:2], index=[7:4] and tag=[31:8] at the default parameters.
REQ-014 The FSM SHALL have the states IDLE, LOOKUP, REFILL, WRITE and RESP.
REQ-015 In IDLE with dm_req=1, the block SHALL register addr/wen/wdata and go to LOOKUP; dm_req in any other state SHALL be ignored.
REQ-016 The requester SHALL hold dm_req and its fields stable until dm_ready; back-to-back requests SHALL be accepted at most every 2 cycles.
REQ-017 In LOOKUP, hit SHALL mean valid[index] and tag match.
REQ-018 On a read hit in LOOKUP, the block SHALL drive dm_ready=1 and dm_rdata=the cached word, then return to IDLE, giving a latency of 1 cycle after acceptance.
REQ-019 On a read miss, the block SHALL go to REFILL, assert mem_rd_req with mem_rd_addr={tag,index,4'b0} until the first mem_rd_valid, and accept exactly WORDS beats in order word 0..WORDS-1.
REQ-020 After the last refill beat, the block SHALL write the tag, set valid and go to RESP.
REQ-021 On a write (hit or miss), the block SHALL go to WRITE and hold mem_wr_req=1 with stable addr, wen and data until mem_wr_ack, which may arrive in the first cycle.
REQ-022 On a write hit, the block SHALL merge the enabled bytes into the cached word in the LOOKUP cycle.
REQ-023 On a write miss, the cache contents SHALL remain unchanged.
REQ-024 On mem_wr_ack, the block SHALL go to RESP.
REQ-025 In RESP, the block SHALL pulse dm_ready=1 for one cycle, with dm_rdata=the requested word for a read or 0 for a write, then go to IDLE.
REQ-026 mem_rd_valid outside REFILL and mem_wr_ack outside WRITE SHALL be ignored.
REQ-027 dm_ready SHALL be 0 in every state and cycle not listed above.
REQ-028 dm_rdata SHALL hold its last value when dm_ready=0.

Reset
REQ-029 Reset SHALL set the state to IDLE and clear all valid bits, whether or not an access is in progress.
REQ-030 Reset SHALL set dm_ready, dm_rdata, mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_wen and mem_wr_data to 0.
REQ-031 Reset SHALL set the refill beat counter to 0.
REQ-032 Reset in the middle of a refill or write SHALL abandon the transaction without a dm_ready pulse, and the partial line SHALL stay invalid.
REQ-033 Tag and data arrays SHALL need no reset.

Structure
REQ-034 Shared package dcache_pkg SHALL hold the FSM state encoding, LINES/WORDS defaults and the derived OFFSET_W, INDEX_W and TAG_W widths.
REQ-035 One sub-module, dcache_data_array, SHALL implement the LINES x WORDS x 32 storage with a byte-enabled synchronous write port and an asynchronous read port.
REQ-036 The tag and valid arrays SHALL be implemented in dcache.

Verification
REQ-037 Cold read: with backing memory at 0x100..0x10C holding 0x11,0x22,0x33,0x44, a read of 0x108 SHALL produce mem_rd_addr=0x100 and 4 beats, then dm_ready with dm_rdata=0x33.
REQ-038 Read hit: a repeat read of 0x10C SHALL give dm_ready in the cycle after acceptance with dm_rdata=0x44 and no mem_rd_req.
REQ-039 Write hit: writing to 0x104 with dm_wen=4'b0010 and dm_wdata=0x0000AB00 SHALL produce mem_wr_* with identical values; a subsequent read of 0x104 SHALL return 0x0000AB22.
REQ-040 Write miss with delayed ack: writing 0x200 with mem_wr_ack after 3 cycles SHALL hold mem_wr_req for 3 cycles and produce dm_ready once; a read of 0x200 SHALL then miss.
REQ-041 Conflict eviction: reading 0x100 then 0x1100 (same index) SHALL refill both, and a further read of 0x100 SHALL miss again.
REQ-042 Reset after the second refill beat: dm_ready SHALL never rise, mem_rd_req SHALL be 0, and a subsequent read of the same line SHALL miss.
